// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch sequencer feeding uart_tx: one start_tx pulse per byte, tx_busy as handshake.
// Optional overflow drop counter (o_drop_cnt) is built when TX_FEEDER_STATS_EN is defined.
//
// state     | meaning
// IDLE      | waiting for a queued byte and an idle uart_tx; pops on exit
// LAUNCH    | o_start_tx high for this single cycle, timeout counter cleared
// WAIT_BUSY | waiting for uart_tx to raise busy; re-launches same byte on timeout
// WAIT_DONE | frame on the line, waiting for busy to fall
module uart_tx_feeder #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_start_tx,
    input  logic              i_tx_busy
`ifdef TX_FEEDER_STATS_EN
    ,
    output logic [15:0]       o_drop_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TO_W  = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [ADDR_W:0] PTR_ONE = 1;
    localparam logic [TO_W-1:0] TO_ONE  = 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0]   wr_ptr_nxt, rd_ptr_nxt;
    logic              push, pop;

    // Full is the registered flag, so a push in the same cycle as a pop is still dropped.
    assign push = i_wr_en && !o_full;
    assign pop  = (state == IDLE) && !o_empty && !i_tx_busy;

    assign wr_ptr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_ptr_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
            o_level <= '0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            o_empty <= (wr_ptr_nxt == rd_ptr_nxt);
            o_full  <= (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]) &&
                       (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
            o_level <= wr_ptr_nxt - rd_ptr_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            to_cnt     <= '0;
            o_tx_data  <= '0;
            o_start_tx <= 1'b0;
        end else begin
            o_start_tx <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        o_tx_data  <= mem[rd_ptr[ADDR_W-1:0]];
                        o_start_tx <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    to_cnt <= '0;
                    state  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        // uart_tx missed the pulse: resend the held byte, no new pop
                        o_start_tx <= 1'b1;
                        state      <= LAUNCH;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TX_FEEDER_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_drop_cnt <= '0;
        end else if (i_wr_en && o_full && (o_drop_cnt != 16'hFFFF)) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small behavioural uart_tx model on the handshake side.
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty;
    logic [4:0] level;
    logic [7:0] tx_data;
    logic       start_tx;
    logic       tx_busy;
`ifdef TX_FEEDER_STATS_EN
    logic [15:0] drop_cnt;
`endif

    logic model_busy = 1'b0;
    logic busy_hold;
    int   busy_len = 4;
    int   ign_req  = 0;
    int   ign_done = 0;
    int   cyc      = 0;
    int   hs_err   = 0;
    int   lvl_err  = 0;
    logic prev_start = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] rx_q[$];
    logic [7:0] st_data[$];
    int         st_cyc[$];

    assign tx_busy = model_busy | busy_hold;

    uart_tx_feeder #(.ADDR_W(4), .DATA_W(8), .BUSY_TIMEOUT(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .o_full     (full),
        .o_empty    (empty),
        .o_level    (level),
        .o_tx_data  (tx_data),
        .o_start_tx (start_tx),
        .i_tx_busy  (tx_busy)
`ifdef TX_FEEDER_STATS_EN
        ,
        .o_drop_cnt (drop_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in: sees the pulse mid-cycle, raises busy after the next edge.
    always @(negedge clk) begin
        if (start_tx) begin
            st_data.push_back(tx_data);
            st_cyc.push_back(cyc);
            if (ign_done < ign_req) begin
                ign_done++;
            end else begin
                rx_q.push_back(tx_data);
                @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (busy_len - 1) @(posedge clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (start_tx && (tx_busy || prev_start)) hs_err++;
        if (level > 5'd16) lvl_err++;
        prev_start = start_tx;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic wait_starts(input int n, input string tag);
        int k = 0;
        while (st_data.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(st_data.size() >= n), 1);
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        for (int k = 0; k < 3000 && quiet < 12; k++) begin
            @(negedge clk);
            if (empty && !tx_busy && !start_tx) quiet++;
            else quiet = 0;
        end
        chk(tag, 32'(quiet >= 12), 1);
    endtask

    initial begin
        int b, bs, pc, k;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        busy_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_start", start_tx, 0);
        chk("rst_data", tx_data, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single byte: pulse lands in the cycle right after the push edge
        b  = rx_q.size();
        bs = st_data.size();
        push(8'h41);
        pc = cyc;
        wait_starts(bs + 1, "single_to");
        chk("single_lat", st_cyc[bs] - pc, 1);
        chk("single_data", st_data[bs], 8'h41);
        wait_idle("single_idle");
        chk("single_empty", empty, 1);
        chk("single_cnt", rx_q.size() - b, 1);

        // burst of 16 with the line held busy so nothing pops
        busy_hold = 1'b1;
        b = rx_q.size();
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            chk("burst_full", full, (i == 15) ? 1 : 0);
            chk("burst_level", level, i + 1);
        end
        busy_hold = 1'b0;
        wait_idle("burst_idle");
        chk("burst_cnt", rx_q.size() - b, 16);
        for (int i = 0; i < 16 && b + i < rx_q.size(); i++) chk("burst_data", rx_q[b + i], i);

        // overflow: 20 pushes into a 16-deep FIFO
        busy_hold = 1'b1;
        b = rx_q.size();
        for (int i = 0; i < 20; i++) push(8'h20 + 8'(i));
        chk("ovf_level", level, 16);
        chk("ovf_full", full, 1);
`ifdef TX_FEEDER_STATS_EN
        chk("ovf_drops", drop_cnt, 4);
`endif
        busy_hold = 1'b0;
        wait_idle("ovf_idle");
        chk("ovf_cnt", rx_q.size() - b, 16);
        for (int i = 0; i < 16 && b + i < rx_q.size(); i++) chk("ovf_data", rx_q[b + i], 8'h20 + i);

        // busy timeout: first pulse ignored, resend 9 cycles later with the same byte
        ign_req = ign_done + 1;
        b  = rx_q.size();
        bs = st_data.size();
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        wait_starts(bs + 2, "to_wait");
        chk("to_level", level, 2);
        chk("to_gap", st_cyc[bs + 1] - st_cyc[bs], 9);
        chk("to_data0", st_data[bs], 8'hA1);
        chk("to_data1", st_data[bs + 1], 8'hA1);
        wait_idle("to_idle");
        chk("to_cnt", rx_q.size() - b, 3);
        for (int i = 0; i < 3 && b + i < rx_q.size(); i++) chk("to_order", rx_q[b + i], 8'hA1 + i);

        // streaming with pushes and pops overlapping; producer respects full
        busy_len = 3;
        b = rx_q.size();
        for (int i = 0; i < 40; i++) begin
            k = 0;
            while (full && k < 100) begin
                @(posedge clk);
                #1 k++;
            end
            push(8'h80 + 8'(i));
        end
        wait_idle("stream_idle");
        chk("stream_cnt", rx_q.size() - b, 40);
        for (int i = 0; i < 40 && b + i < rx_q.size(); i++) chk("stream_data", rx_q[b + i], 8'h80 + i);

        // reset while a frame is on the line with three bytes still queued
        busy_len = 20;
        push(8'h61);
        push(8'h62);
        push(8'h63);
        push(8'h64);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_level", level, 3);
        chk("mid_busy", model_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_start", start_tx, 0);
        chk("mid_rst_data", tx_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        b  = rx_q.size();
        bs = st_data.size();
        push(8'h55);
        chk("post_busy", tx_busy, 1);
        k = 0;
        while (tx_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("post_busy_fell", tx_busy, 0);
        chk("post_no_start", st_data.size() - bs, 0);
        wait_idle("post_idle");
        chk("post_cnt", rx_q.size() - b, 1);
        if (rx_q.size() > b) chk("post_data", rx_q[b], 8'h55);

        chk("handshake", hs_err, 0);
        chk("level_max", lvl_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
